// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared FSM encoding, framing constants and state helpers for rom_loader.
package rom_loader_pkg;
  typedef enum logic [2:0] {
    st_idle, st_sync, st_len, st_data, st_write, st_csum, st_done, st_err
  } state_t;
  localparam logic [7:0] sync_byte = 8'hA5;
  localparam int len_bytes = 4;
  function automatic logic is_busy(input state_t s);
    return s inside {st_sync, st_len, st_data, st_write, st_csum};
  endfunction
  function automatic logic takes_bytes(input state_t s);
    return s inside {st_sync, st_len, st_data, st_csum};
  endfunction
endpackage

// File: rtl/rom_loader_byte_packer.sv
// byte_packer: little-endian byte-to-word shift register; word/full show the result including the byte offered now.
module byte_packer #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  input  logic [7:0]    din,
  output logic [DW-1:0] word,
  output logic          full
);
  localparam int NB = DW / 8;
  localparam int CW = $clog2(NB + 1);
  logic [DW-1:0] sr;
  logic [CW-1:0] cnt;
  logic [DW+7:0] cat;
  assign cat = {din, sr};
  assign word = cat[DW+7:8];
  assign full = en && cnt == CW'(NB - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sr <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr <= '0;
      cnt <= '0;
    end else if (en) begin
      sr <= word;
      cnt <= full ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/rom_loader.sv
// rom_loader: loads a framed byte stream (sync, LE length, LE data words) into ROM writes.
// Define LOADER_CSUM_EN to require a trailing XOR checksum byte over the data bytes.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int             DW        = 32,
  parameter int             AW        = 32,
  parameter logic [AW-1:0]  BASE_ADDR = '0,
  parameter int             MAX_WORDS = 4096
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          wen,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          busy,
  output logic          done,
  output logic          err
);
  state_t state, nxt;
  logic [31:0] len, len_nxt, idx;
  logic [1:0] lcnt;
  logic fire, start_ok, pk_full;
  logic [DW-1:0] pk_word;
  assign fire = rx_valid && rx_ready;
  assign start_ok = start && state inside {st_idle, st_done, st_err};
  assign len_nxt = {rx_data, len[31:8]};
  byte_packer #(.DW(DW)) u_packer (
    .clk(clk), .rstn(rstn), .clr(start_ok), .en(fire && state == st_data),
    .din(rx_data), .word(pk_word), .full(pk_full)
  );
`ifdef LOADER_CSUM_EN
  localparam state_t st_end = st_csum;
  logic [7:0] csum;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) csum <= '0;
    else if (start_ok) csum <= '0;
    else if (fire && state == st_data) csum <= csum ^ rx_data;
`else
  localparam state_t st_end = st_done;
`endif
  always_comb begin
    nxt = state;
    case (state)
      st_idle, st_done, st_err: nxt = start ? st_sync : state;
      st_sync:  nxt = fire && rx_data == sync_byte ? st_len : state;
      st_len:   nxt = !(fire && lcnt == 2'(len_bytes - 1)) ? state :
                      len_nxt == '0 ? st_end :
                      len_nxt > 32'(MAX_WORDS) ? st_err : st_data;
      st_data:  nxt = fire && pk_full ? st_write : state;
      st_write: nxt = idx + 32'd1 == len ? st_end : st_data;
`ifdef LOADER_CSUM_EN
      st_csum:  nxt = !fire ? state : rx_data == csum ? st_done : st_err;
`endif
      default:  nxt = st_idle;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= st_idle;
      rx_ready <= 1'b0;
      wen <= 1'b0;
      w_addr <= BASE_ADDR;
      w_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      len <= '0;
      idx <= '0;
      lcnt <= '0;
    end else begin
      state <= nxt;
      rx_ready <= takes_bytes(nxt);
      wen <= nxt == st_write;
      busy <= is_busy(nxt);
      done <= nxt == st_done;
      err <= nxt == st_err;
      if (start_ok) begin
        len <= '0;
        idx <= '0;
        lcnt <= '0;
      end
      if (state == st_len && fire) begin
        len <= len_nxt;
        lcnt <= lcnt + 2'd1;
      end
      if (nxt == st_write) begin
        w_addr <= BASE_ADDR + AW'({idx, 2'b00});
        w_data <= pk_word;
      end
      if (state == st_write) idx <= idx + 32'd1;
    end
endmodule
